// File: rtl/des_pkg.sv
// Shared DES definitions: half/subkey widths, E and P tables (FIPS 46-3 numbering),
// S-box contents and the table-driven helper functions used by the round datapath.
package des_pkg;

  localparam int DES_HALF_W   = 32;
  localparam int DES_SUBKEY_W = 48;

  // Entries are 1-indexed, MSB-first: DES bit n lives at vector index WIDTH-n.
  localparam logic [5:0] E_TABLE [DES_SUBKEY_W] = '{
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
    6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
    6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
  };

  localparam logic [5:0] P_TABLE [DES_HALF_W] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  // Each box is 64 nibbles, row-major (row 0 col 0 in the top nibble).
  localparam logic [255:0] SBOX_TABLE [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [DES_SUBKEY_W-1:0] des_expand(input logic [DES_HALF_W-1:0] r);
    logic [DES_SUBKEY_W-1:0] e;
    logic [4:0] pos;
    e = '0;
    for (int i = 0; i < DES_SUBKEY_W; i++) begin
      pos = 5'(6'd32 - E_TABLE[i]);
      e[DES_SUBKEY_W-1-i] = r[pos];
    end
    return e;
  endfunction

  function automatic logic [DES_HALF_W-1:0] des_perm_p(input logic [DES_HALF_W-1:0] s);
    logic [DES_HALF_W-1:0] p;
    logic [4:0] pos;
    p = '0;
    for (int i = 0; i < DES_HALF_W; i++) begin
      pos = 5'(6'd32 - P_TABLE[i]);
      p[DES_HALF_W-1-i] = s[pos];
    end
    return p;
  endfunction

  // Row = {din[5], din[0]}, column = din[4:1]; nibble offset = 4 * (row*16 + col).
  function automatic logic [3:0] des_sbox_lookup(input logic [2:0] box, input logic [5:0] din);
    logic [7:0] shamt;
    shamt = {din[5], din[0], din[4:1], 2'b00};
    return SBOX_TABLE[box][8'd255 - shamt -: 4];
  endfunction

endpackage

// File: rtl/des_f.sv
// DES f-function split at the key XOR: x = E(r)^K leaves on one port and the
// S-box/P half consumes x_sbox, so the caller may place a register between them.
module des_f import des_pkg::*; (
  input  logic [DES_HALF_W-1:0]   r,
  input  logic [DES_SUBKEY_W-1:0] subkey,
  output logic [DES_SUBKEY_W-1:0] x,
  input  logic [DES_SUBKEY_W-1:0] x_sbox,
  output logic [DES_HALF_W-1:0]   f
);

  logic [5:0]            sbox_in  [8];
  logic [3:0]            sbox_out [8];
  logic [DES_HALF_W-1:0] s;

  assign x = des_expand(r) ^ subkey;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slice
      assign sbox_in[gi]             = x_sbox[DES_SUBKEY_W-1-6*gi -: 6];
      assign s[DES_HALF_W-1-4*gi -: 4] = sbox_out[gi];
    end
  endgenerate

  des_sbox1 u_sbox1 (.din(sbox_in[0]), .dout(sbox_out[0]));
  des_sbox2 u_sbox2 (.din(sbox_in[1]), .dout(sbox_out[1]));
  des_sbox3 u_sbox3 (.din(sbox_in[2]), .dout(sbox_out[2]));
  des_sbox4 u_sbox4 (.din(sbox_in[3]), .dout(sbox_out[3]));
  des_sbox5 u_sbox5 (.din(sbox_in[4]), .dout(sbox_out[4]));
  des_sbox6 u_sbox6 (.din(sbox_in[5]), .dout(sbox_out[5]));
  des_sbox7 u_sbox7 (.din(sbox_in[6]), .dout(sbox_out[6]));
  des_sbox8 u_sbox8 (.din(sbox_in[7]), .dout(sbox_out[7]));

  assign f = des_perm_p(s);

endmodule

// File: rtl/des_sbox.sv
// The eight DES substitution boxes, each a 6-in / 4-out combinational lookup.
module des_sbox1 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = des_sbox_lookup(3'd0, din);
endmodule

module des_sbox2 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = des_sbox_lookup(3'd1, din);
endmodule

module des_sbox3 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = des_sbox_lookup(3'd2, din);
endmodule

module des_sbox4 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = des_sbox_lookup(3'd3, din);
endmodule

module des_sbox5 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = des_sbox_lookup(3'd4, din);
endmodule

module des_sbox6 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = des_sbox_lookup(3'd5, din);
endmodule

module des_sbox7 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = des_sbox_lookup(3'd6, din);
endmodule

module des_sbox8 import des_pkg::*; (input logic [5:0] din, output logic [3:0] dout);
  assign dout = des_sbox_lookup(3'd7, din);
endmodule

// File: rtl/des_round_stage.sv
// One pipelined DES Feistel round with valid/ready handshake; MID_REG=1 adds a
// register after the key XOR (latency 2), MID_REG=0 gives a single-stage round.
module des_round_stage import des_pkg::*; #(
  parameter int unsigned MID_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DES_HALF_W-1:0]   in_l,
  input  logic [DES_HALF_W-1:0]   in_r,
  input  logic [DES_SUBKEY_W-1:0] in_subkey,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DES_HALF_W-1:0]   out_l,
  output logic [DES_HALF_W-1:0]   out_r,
  output logic                    out_last
);

  logic                    stage2_ready;
  logic                    src_valid;
  logic                    src_last;
  logic [DES_HALF_W-1:0]   src_l;
  logic [DES_HALF_W-1:0]   src_r;
  logic [DES_SUBKEY_W-1:0] x_comb;
  logic [DES_SUBKEY_W-1:0] x_src;
  logic [DES_HALF_W-1:0]   f_val;
  logic [DES_HALF_W-1:0]   nr;
  logic [DES_HALF_W-1:0]   next_l;
  logic [DES_HALF_W-1:0]   next_r;

  logic                    out_valid_reg;
  logic                    out_last_reg;
  logic [DES_HALF_W-1:0]   out_l_reg;
  logic [DES_HALF_W-1:0]   out_r_reg;

  des_f u_f (
    .r      (in_r),
    .subkey (in_subkey),
    .x      (x_comb),
    .x_sbox (x_src),
    .f      (f_val)
  );

  assign stage2_ready = !out_valid_reg || out_ready;

  generate
    if (MID_REG != 0) begin : g_mid
      logic                    v1_reg;
      logic                    last1_reg;
      logic [DES_HALF_W-1:0]   l1_reg;
      logic [DES_HALF_W-1:0]   r1_reg;
      logic [DES_SUBKEY_W-1:0] x_reg;

      // When input is blocked the held beat may still drain into an empty output stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1_reg    <= 1'b0;
          last1_reg <= 1'b0;
          l1_reg    <= '0;
          r1_reg    <= '0;
          x_reg     <= '0;
        end else if (in_ready) begin
          v1_reg <= in_valid;
          if (in_valid) begin
            x_reg     <= x_comb;
            l1_reg    <= in_l;
            r1_reg    <= in_r;
            last1_reg <= in_last;
          end
        end else if (stage2_ready) begin
          v1_reg <= 1'b0;
        end
      end

      assign in_ready  = !v1_reg || out_ready;
      assign src_valid = v1_reg;
      assign src_l     = l1_reg;
      assign src_r     = r1_reg;
      assign src_last  = last1_reg;
      assign x_src     = x_reg;
    end else begin : g_no_mid
      assign in_ready  = stage2_ready;
      assign src_valid = in_valid;
      assign src_l     = in_l;
      assign src_r     = in_r;
      assign src_last  = in_last;
      assign x_src     = x_comb;
    end
  endgenerate

  // The final round skips the half swap so the result feeds IP^-1 directly.
  assign nr     = src_l ^ f_val;
  assign next_l = src_last ? nr : src_r;
  assign next_r = src_last ? src_r : nr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_l_reg     <= '0;
      out_r_reg     <= '0;
    end else if (stage2_ready) begin
      out_valid_reg <= src_valid;
      if (src_valid) begin
        out_l_reg    <= next_l;
        out_r_reg    <= next_r;
        out_last_reg <= src_last;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_l     = out_l_reg;
  assign out_r     = out_r_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_des_round_stage.sv
// Scoreboard bench for des_round_stage: drives known DES round vectors into a
// MID_REG=1 and a MID_REG=0 instance in turn and checks data, latency and flow control.
module tb_des_round_stage;

  typedef struct packed {
    logic        last;
    logic [31:0] l;
    logic [31:0] r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic [31:0] in_l;
  logic [31:0] in_r;
  logic [47:0] in_subkey;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_m, out_valid_m, out_last_m;
  logic [31:0] out_l_m, out_r_m;
  logic        in_ready_n, out_valid_n, out_last_n;
  logic [31:0] out_l_n, out_r_n;

  logic        in_ready, out_valid, out_last;
  logic [31:0] out_l, out_r;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_deliv = 0;
  int last_gap = 0;
  int accept_cnt = 0;
  int deliv_cnt = 0;
  int mid = 1;
  int lat, d0, a0;

  exp_t exp_q[$];
  exp_t cur_exp = '0;

  // Consecutive rounds 1..3 of the classic 133457799BBCDFF1 key example.
  logic [31:0] vec_l  [3] = '{32'hCC00CCFF, 32'hF0AAF0AA, 32'hEF4A6544};
  logic [31:0] vec_r  [3] = '{32'hF0AAF0AA, 32'hEF4A6544, 32'hCC017709};
  logic [47:0] vec_k  [3] = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99};
  logic [31:0] vec_nr [3] = '{32'hEF4A6544, 32'hCC017709, 32'hA25C0BF4};

  always #5 clk = ~clk;

  des_round_stage #(.MID_REG(1)) dut_mid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(in_ready_m),
    .in_l(in_l), .in_r(in_r), .in_subkey(in_subkey), .in_last(in_last),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_l(out_l_m), .out_r(out_r_m),
    .out_last(out_last_m)
  );

  des_round_stage #(.MID_REG(0)) dut_no_mid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(in_ready_n),
    .in_l(in_l), .in_r(in_r), .in_subkey(in_subkey), .in_last(in_last),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_l(out_l_n), .out_r(out_r_n),
    .out_last(out_last_n)
  );

  assign in_ready  = sel ? in_ready_m  : in_ready_n;
  assign out_valid = sel ? out_valid_m : out_valid_n;
  assign out_last  = sel ? out_last_m  : out_last_n;
  assign out_l     = sel ? out_l_m     : out_l_n;
  assign out_r     = sel ? out_r_m     : out_r_n;

  task automatic check_val(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s mid=%0d got=%0h exp=%0h t=%0t", tag, mid, got, exp, $time);
    end
  endtask

  // Transfers happen on the following rising edge; sample here, mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_q.push_back(cur_exp);
        accept_cnt++;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out", out_valid, 0);
        end else begin
          check_val(out_ready ? "out_data" : "stall_hold", {out_last, out_l, out_r}, exp_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            deliv_cnt++;
            last_gap   = cyc - last_deliv;
            last_deliv = cyc;
          end
        end
      end
    end
  end

  task automatic send(input int idx, input logic last);
    logic ok;
    in_l      = vec_l[idx];
    in_r      = vec_r[idx];
    in_subkey = vec_k[idx];
    in_last   = last;
    cur_exp   = last ? {1'b1, vec_nr[idx], vec_r[idx]} : {1'b0, vec_r[idx], vec_nr[idx]};
    in_valid  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_val("accepted", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sel = 1'b1; in_valid = 1'b0; in_l = '0; in_r = '0;
    in_subkey = '0; in_last = 1'b0; out_ready = 1'b0;

    for (int m = 1; m >= 0; m--) begin
      sel = (m == 1);
      mid = m;

      // Reset state
      rst_n = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_outputs", {out_valid, out_last, out_l, out_r}, 0);
      rst_n = 1'b1;
      idle(1);
      check_val("rst_in_ready", in_ready, 1);
      check_val("idle_out_valid", out_valid, 0);
      out_ready = 1'b1;

      // Single beat, latency from presentation to out_valid
      send(0, 1'b0);
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check_val("latency", lat, mid + 1);
      wait_drain();

      // Back-to-back rounds 1 and 2
      send(0, 1'b0);
      send(1, 1'b0);
      wait_drain();
      check_val("no_bubble", last_gap, 1);

      // Final-round beats mixed with normal ones
      send(0, 1'b1);
      send(2, 1'b0);
      send(2, 1'b1);
      wait_drain();

      // Stall with three beats offered
      d0 = deliv_cnt;
      a0 = accept_cnt;
      out_ready = 1'b0;
      fork
        begin
          send(0, 1'b0);
          send(1, 1'b0);
          send(2, 1'b0);
        end
        begin
          repeat (5) @(posedge clk);
          #1;
          check_val("stall_accepts", accept_cnt - a0, mid + 1);
          check_val("stall_in_ready", in_ready, 0);
          check_val("stall_out_valid", out_valid, 1);
          out_ready = 1'b1;
          #1;
          check_val("release_in_ready", in_ready, 1);
        end
      join
      wait_drain();
      check_val("stall_delivered", deliv_cnt - d0, 3);

      // in_valid gaps mid-stream
      d0 = deliv_cnt;
      send(0, 1'b0);
      idle(1);
      send(1, 1'b0);
      idle(2);
      send(2, 1'b1);
      wait_drain();
      check_val("gap_delivered", deliv_cnt - d0, 3);

      // Reset with beats in flight
      send(0, 1'b0);
      send(1, 1'b0);
      check_val("inflight_valid", out_valid, 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check_val("rst_async", {out_valid, out_last, out_l, out_r}, 0);
      idle(2);
      rst_n = 1'b1;
      d0 = deliv_cnt;
      idle(6);
      check_val("rst_no_output", deliv_cnt - d0, 0);
      send(1, 1'b0);
      wait_drain();
      check_val("post_rst_delivered", deliv_cnt - d0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
